mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access unit. Converts EX/MEM load/store
//               controls into a req/ack transaction on the data-memory port,
//               stalls the pipeline (busywait) until the access completes and
//               returns sign/zero-extended load data to MEM/WB.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      max REQ cycles awaiting mem_ack before abort with err
//                (0 = wait forever)
// Optional feature
//   MEM_MISALIGN_TRAP_EN  defined: misaligned LH/LHU/SH/LW/SW issue no
//                         request and pulse err. Undefined: low address bits
//                         are ignored (forced aligned).
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   IN_mem_read/write   load / store request from EX/MEM
//   IN_func3            RV32 funct3 (size / signedness)
//   IN_addr, IN_wdata   byte address, store data
//   busywait            pipeline stall
//   load_data           formatted load result (valid in DONE)
//   err                 1-cycle pulse on timeout / misaligned trap
//   mem_req/we/addr/byteen/wdata, mem_rdata, mem_ack   memory port
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IN_mem_read,
  input  logic        IN_mem_write,
  input  logic [2:0]  IN_func3,
  input  logic [31:0] IN_addr,
  input  logic [31:0] IN_wdata,
  output logic        busywait,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         func3_q;
  logic [1:0]         lane_q;
  logic               busy_c;

  // ---------------- request decode (IDLE-side inputs) ----------------
  logic        req_any;
  logic        is_byte, is_half, is_word;
  logic        misalign;
  logic [3:0]  byteen_in;
  logic [31:0] wdata_in;

  assign req_any = IN_mem_read | IN_mem_write;
  assign is_byte = (IN_func3[1:0] == 2'b00);
  assign is_half = (IN_func3[1:0] == 2'b01);
  assign is_word = (IN_func3 == 3'b010);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (is_half & IN_addr[0]) | (is_word & (IN_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Only addr[1] feeds the halfword lane and words always use all lanes,
  // so unused low address bits are effectively forced aligned.
  always_comb begin
    byteen_in = 4'hF;
    wdata_in  = IN_wdata;
    if (IN_mem_write) begin
      if (is_byte) begin
        byteen_in = 4'b0001 << IN_addr[1:0];
        wdata_in  = {4{IN_wdata[7:0]}};
      end else if (is_half) begin
        byteen_in = 4'b0011 << {IN_addr[1], 1'b0};
        wdata_in  = {2{IN_wdata[15:0]}};
      end
    end
  end

  // ---------------- timeout ----------------
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack;

  // ---------------- load formatting ----------------
  logic [31:0] rdata_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign rdata_shift = mem_rdata >> {lane_q, 3'b000};
  assign byte_sel    = rdata_shift[7:0];
  assign half_sel    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_fmt = mem_rdata;
    case (func3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        // Combinational so EX/MEM sees the stall in the same cycle.
        busy_c = req_any;
        if (req_any) state_next = misalign ? DONE : REQ;
      end
      REQ: begin
        busy_c = 1'b1;
        if (mem_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset also masks the combinational stall so all outputs read 0 in reset.
  assign busywait = busy_c & ~reset;
  assign mem_req  = (state == REQ);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      func3_q    <= 3'b000;
      lane_q     <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= 30'h0;
      mem_byteen <= 4'h0;
      mem_wdata  <= 32'h0;
      load_data  <= 32'h0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_any) begin
            func3_q    <= IN_func3;
            lane_q     <= IN_addr[1:0];
            mem_we     <= IN_mem_write;
            mem_addr   <= IN_addr[31:2];
            mem_byteen <= byteen_in;
            mem_wdata  <= wdata_in;
            if (misalign) begin
              err       <= 1'b1;
              load_data <= 32'h0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            if (!mem_we) load_data <= load_fmt;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            load_data <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit (TIMEOUT = 4).
//               A transaction-level model sets per-cycle expectations that a
//               single compare process checks on every falling edge; literal
//               checks pin the model on the documented examples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TIMEOUT_TB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IN_mem_read, IN_mem_write;
  logic [2:0]  IN_func3;
  logic [31:0] IN_addr, IN_wdata;
  logic        busywait;
  logic [31:0] load_data;
  logic        err;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_access_unit #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk(clk), .reset(reset),
    .IN_mem_read(IN_mem_read), .IN_mem_write(IN_mem_write),
    .IN_func3(IN_func3), .IN_addr(IN_addr), .IN_wdata(IN_wdata),
    .busywait(busywait), .load_data(load_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int req_cnt = 0;

  // Per-cycle expectations written by the stimulus tasks
  bit          cmp_en = 0;
  bit          exp_busy, exp_req, exp_err, exp_we;
  logic [31:0] exp_ld;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: spec rules as plain arithmetic ----------------
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input bit wr, input logic [31:0] a);
    if (!wr) return 4'hF;
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic bit trap_model(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    if (busywait) busy_cnt++;
    if (mem_req)  req_cnt++;
    if (cmp_en) begin
      chk("busywait", {31'h0, busywait}, {31'h0, exp_busy});
      chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
      chk("err", {31'h0, err}, {31'h0, exp_err});
      chk("load_data", load_data, exp_ld);
      if (exp_req) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        chk("mem_addr", {2'b00, mem_addr}, {2'b00, exp_addr});
        chk("mem_byteen", {28'h0, mem_byteen}, {28'h0, exp_be});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  // ack_at: REQ cycle (1-based) in which mem_ack is pulsed; 0 = never.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int ack_at);
    bit trap, to;
    trap = trap_model(f3, a);
    to   = 1'b0;
    IN_mem_read = rd; IN_mem_write = wr; IN_func3 = f3; IN_addr = a; IN_wdata = wd;
    mem_ack = 1'b0;
    exp_busy = 1; exp_req = 0; exp_err = 0;
    @(posedge clk); #1;
    if (!trap) begin
      for (int k = 1; k <= 1000; k++) begin
        exp_busy = 1; exp_req = 1; exp_we = wr;
        exp_addr = a[31:2]; exp_be = be_model(f3, wr, a); exp_wd = wd_model(f3, wd);
        mem_ack   = (k == ack_at);
        mem_rdata = mem_ack ? rword : $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (k == ack_at) break;
        if (k == TIMEOUT_TB) begin to = 1'b1; break; end
      end
    end
    // DONE cycle: inputs still asserted, pipeline released
    exp_busy = 0; exp_req = 0; exp_err = trap || to;
    if (trap || to) exp_ld = 32'h0;
    else if (!wr)   exp_ld = fmt_load(f3, a, rword);
    @(posedge clk); #1;
    IN_mem_read = 0; IN_mem_write = 0;
    exp_err = 0;
  endtask

  task automatic idle(input bit ack_in);
    mem_ack = ack_in;
    mem_rdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1; IN_mem_read = 0; IN_mem_write = 0; IN_func3 = 0; IN_addr = 0; IN_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    exp_busy = 0; exp_req = 0; exp_err = 0; exp_we = 0; exp_ld = 0;
    exp_addr = 0; exp_be = 0; exp_wd = 0;
    @(posedge clk); #1;
    // Reset state
    chk("rst_busywait", {31'h0, busywait}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
    chk("rst_mem_byteen", {28'h0, mem_byteen}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 0;
    cmp_en = 1;
    idle(0);

    // LW 0x100, ack in 3rd REQ cycle -> 4 stall cycles
    busy_cnt = 0;
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    chk("lw_stall_cycles", busy_cnt, 4);
    chk("lw_data", load_data, 32'hDEADBEEF);
    idle(0);

    // Byte/half loads, ack in first REQ cycle -> 2 stall cycles
    busy_cnt = 0;
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1);
    chk("lb_stall_cycles", busy_cnt, 2);
    chk("lb_data", load_data, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1);
    chk("lbu_data", load_data, 32'h00000080);
    access(1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 2);
    chk("lb_lane1_data", load_data, 32'h0000007F);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 1);
    chk("lh_data", load_data, 32'hFFFF80FF);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 1);
    chk("lhu_data", load_data, 32'h000080FF);
    idle(0);

    // Stores: load_data must be unchanged
    access(0, 1, 3'b000, 32'h202, 32'h12345678, 32'h0, 2);
    chk("sb_we", {31'h0, mem_we}, 32'h1);
    chk("sb_byteen", {28'h0, mem_byteen}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'h78787878);
    chk("sb_addr", {2'b00, mem_addr}, 32'h80);
    chk("sb_load_kept", load_data, 32'h000080FF);
    access(0, 1, 3'b001, 32'h206, 32'hAABBCCDD, 32'h0, 1);
    chk("sh_byteen", {28'h0, mem_byteen}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCCDDCCDD);
    access(0, 1, 3'b010, 32'h208, 32'h01020304, 32'h0, 1);
    chk("sw_byteen", {28'h0, mem_byteen}, 32'hF);
    // Read and write together -> write
    access(1, 1, 3'b010, 32'h210, 32'hCAFEF00D, 32'h55555555, 1);
    chk("rw_is_write", {31'h0, mem_we}, 32'h1);
    chk("rw_load_kept", load_data, 32'h000080FF);
    idle(0);

    // Misaligned word load
    busy_cnt = 0;
    req_cnt = 0;
    access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_no_req", req_cnt, 0);
    chk("mis_stall_cycles", busy_cnt, 1);
    chk("mis_data", load_data, 32'h0);
`else
    chk("mis_addr", {2'b00, mem_addr}, 32'h40);
    chk("mis_data", load_data, 32'h11223344);
`endif
    idle(0);

    // Timeout: never ack
    req_cnt = 0;
    access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0);
    chk("to_req_cycles", req_cnt, TIMEOUT_TB);
    chk("to_data", load_data, 32'h0);
    idle(1);   // stray ack outside REQ is ignored
    idle(0);

    // Reset during REQ
    access(1, 0, 3'b010, 32'h104, 32'h0, 32'h12340000, 1);
    cmp_en = 0;
    IN_mem_read = 1; IN_func3 = 3'b010; IN_addr = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    #2 reset = 1;
    #1;
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_busywait", {31'h0, busywait}, 32'h0);
    chk("midrst_load_data", load_data, 32'h0);
    IN_mem_read = 0;
    @(posedge clk); #1;
    reset = 0;
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("late_ack_req", {31'h0, mem_req}, 32'h0);
    chk("late_ack_busy", {31'h0, busywait}, 32'h0);
    chk("late_ack_data", load_data, 32'h0);
    chk("late_ack_err", {31'h0, err}, 32'h0);
    exp_busy = 0; exp_req = 0; exp_err = 0; exp_ld = 32'h0;
    cmp_en = 1;
    idle(0);
    idle(0);
    // Back to normal operation
    access(1, 0, 3'b100, 32'h502, 32'h0, 32'h00C30000, 1);
    chk("post_rst_lbu", load_data, 32'h000000C3);
    idle(0);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
